// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: grants the shared byte-wide SPI driver to one of two OLED byte sources, one transaction at a time.
// Define OLED_ARB_RR_EN for round-robin on simultaneous IDLE starts; default is fixed ch0 priority.
module oled_spi_arbiter #(
    parameter int unsigned HOLD_TIMEOUT = 255,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       ch0_start,
    input  logic [7:0] ch0_data,
    input  logic       ch0_dc,
    input  logic       ch0_last,
    output logic       ch0_ready,
    input  logic       ch1_start,
    input  logic [7:0] ch1_data,
    input  logic       ch1_dc,
    input  logic       ch1_last,
    output logic       ch1_ready,
    output logic       spi_transmitt,
    output logic [7:0] spi_data,
    output logic       spi_cs_release,
    input  logic       spi_ready,
    output logic       oled_dc,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_TIMEOUT - 1);
    localparam logic [7:0] BUSY_LIM = 8'(BUSY_TIMEOUT - 1);
    state_t     state_q, state_d;
    logic [7:0] data_q, data_d, cnt_q, cnt_d;
    logic       dc_q, dc_d, last_q, last_d, owner_q, owner_d, busy_q, busy_d, tmo_q, tmo_d;
    logic       go0, go1, win1, latch;
    assign ch0_ready = (state_q == IDLE) ? spi_ready : ((state_q == HOLD) && !owner_q);
    assign ch1_ready = (state_q == IDLE) ? spi_ready : ((state_q == HOLD) && owner_q);
    assign go0 = ch0_start && ch0_ready;
    assign go1 = ch1_start && ch1_ready;
    // In HOLD only the owner can be ready, so these also resolve the HOLD case.
`ifdef OLED_ARB_RR_EN
    assign win1 = go1 && (!go0 || !owner_q);
`else
    assign win1 = go1 && !go0;
`endif
    assign latch = go0 || go1;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dc_d    = dc_q;
        last_d  = last_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (latch) begin
            data_d  = win1 ? ch1_data : ch0_data;
            dc_d    = win1 ? ch1_dc : ch0_dc;
            last_d  = win1 ? ch1_last : ch0_last;
            owner_d = win1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = LAUNCH;
        end else begin
            case (state_q)
                LAUNCH: begin
                    state_d = WAIT_BUSY;
                    cnt_d   = '0;
                end
                // A driver that finishes before we see ready drop must not hang us here.
                WAIT_BUSY: if (!spi_ready || cnt_q >= BUSY_LIM) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end
                WAIT_DONE: if (spi_ready) begin
                    state_d = last_q ? IDLE : HOLD;
                    busy_d  = !last_q;
                    cnt_d   = '0;
                end
                HOLD: if (cnt_q >= HOLD_LIM) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dc_q    <= 1'b0;
            last_q  <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end
    assign spi_transmitt  = (state_q == LAUNCH);
    assign spi_data       = data_q;
    assign spi_cs_release = last_q;
    assign oled_dc        = dc_q;
    assign owner          = owner_q;
    assign busy           = busy_q;
    assign timeout_err    = tmo_q;
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb_oled_spi_arbiter: directed bench with a 4-cycle SPI driver model and a launch log.
module tb_oled_spi_arbiter;
    logic       clk = 0, resetn = 0;
    logic       ch0_start = 0, ch0_dc = 0, ch0_last = 0, ch1_start = 0, ch1_dc = 0, ch1_last = 0;
    logic [7:0] ch0_data = 0, ch1_data = 0;
    logic       ch0_ready, ch1_ready, spi_transmitt, spi_cs_release, oled_dc, owner, busy, timeout_err;
    logic [7:0] spi_data;
    logic       spi_ready = 1, stuck = 0;
    int         scnt = 0, nl = 0, n_chk = 0, n_pass = 0, base, k, t;
    logic [7:0] log_data [64];
    logic       log_rel [64], log_dc [64], log_own [64];
    logic [1:0] hold_r;
    logic       seen, lat, exp_own;

    oled_spi_arbiter dut (
        .clk_in(clk), .resetn(resetn),
        .ch0_start(ch0_start), .ch0_data(ch0_data), .ch0_dc(ch0_dc), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
        .ch1_start(ch1_start), .ch1_data(ch1_data), .ch1_dc(ch1_dc), .ch1_last(ch1_last), .ch1_ready(ch1_ready),
        .spi_transmitt(spi_transmitt), .spi_data(spi_data), .spi_cs_release(spi_cs_release),
        .spi_ready(spi_ready), .oled_dc(oled_dc), .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    // Driver model: ready low for 4 cycles after a launch; 'stuck' makes it ignore launches.
    always @(posedge clk) begin
        if (!resetn) begin
            spi_ready <= 1'b1;
            scnt      <= 0;
        end else if (spi_transmitt && !stuck) begin
            spi_ready <= 1'b0;
            scnt      <= 3;
        end else if (!spi_ready) begin
            if (scnt == 0) spi_ready <= 1'b1;
            else scnt <= scnt - 1;
        end
    end

    always @(posedge clk) begin
        if (resetn && spi_transmitt && nl < 64) begin
            log_data[nl] <= spi_data;
            log_rel[nl]  <= spi_cs_release;
            log_dc[nl]   <= oled_dc;
            log_own[nl]  <= owner;
            nl           <= nl + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input bit ch, input logic [7:0] d, input logic dc, input logic last);
        int w = 0;
        while (!(ch ? ch1_ready : ch0_ready) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(w < 1000), 1);
        if (ch) begin
            ch1_start = 1; ch1_data = d; ch1_dc = dc; ch1_last = last;
        end else begin
            ch0_start = 1; ch0_data = d; ch0_dc = dc; ch0_last = last;
        end
        @(negedge clk);
        if (ch) ch1_start = 0;
        else ch0_start = 0;
        lat = spi_transmitt;
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        @(negedge clk);
        while (busy && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {ch0_ready, ch1_ready}, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {spi_transmitt, spi_data, oled_dc, spi_cs_release, owner, timeout_err}, 0);
        resetn = 1;
        @(negedge clk);

        // 1: ch0 three-byte command transaction
        base = nl;
        send(0, 8'hAE, 0, 0);
        chk("t1_latency", lat, 1);
        chk("t1_busy", busy, 1);
        send(0, 8'hD5, 0, 0);
        send(0, 8'h8D, 0, 1);
        wait_idle("t1_idle");
        chk("t1_count", nl - base, 3);
        chk("t1_b0", {log_data[base], log_rel[base]}, {8'hAE, 1'b0});
        chk("t1_b1", {log_data[base+1], log_rel[base+1]}, {8'hD5, 1'b0});
        chk("t1_b2", {log_data[base+2], log_rel[base+2], log_own[base+2]}, {8'h8D, 1'b1, 1'b0});

        // 2: ch1 locked out while ch0 holds the grant
        base = nl;
        send(0, 8'hA8, 0, 0);
        t = 0;
        while (!ch0_ready && t < 100) begin @(negedge clk); t++; end
        ch1_start = 1; ch1_data = 8'h11; ch1_dc = 1; ch1_last = 1;
        seen = 0;
        repeat (20) begin @(negedge clk); seen |= ch1_ready; end
        chk("t2_ch1_blocked", seen, 0);
        chk("t2_no_launch", nl - base, 1);
        send(0, 8'h3F, 0, 1);
        t = 0;
        while (!(spi_transmitt && spi_data == 8'h11) && t < 100) begin @(negedge clk); t++; end
        ch1_start = 0;
        chk("t2_ch1_launched", 32'(t < 100), 1);
        wait_idle("t2_idle");
        chk("t2_count", nl - base, 3);
        chk("t2_order", {log_data[base+1], log_own[base+1], log_data[base+2], log_own[base+2], log_dc[base+2]},
            {8'h3F, 1'b0, 8'h11, 1'b1, 1'b1});
        chk("t2_owner", owner, 1);

        // 3: simultaneous starts in IDLE, twice
        for (int r = 0; r < 2; r++) begin
            base = nl;
            ch0_start = 1; ch0_data = 8'h01; ch0_dc = 0; ch0_last = 1;
            ch1_start = 1; ch1_data = 8'h02; ch1_dc = 1; ch1_last = 1;
            @(negedge clk);
            ch0_start = 0; ch1_start = 0;
            wait_idle("t3_idle");
`ifdef OLED_ARB_RR_EN
            exp_own = (r == 1);
`else
            exp_own = 1'b0;
`endif
            chk("t3_count", nl - base, 1);
            chk("t3_winner", {log_own[base], log_data[base]}, {exp_own, exp_own ? 8'h02 : 8'h01});
        end

        // 4: ch1 goes silent mid-transaction
        send(1, 8'h55, 1, 0);
        chk("t4_latency", lat, 1);
        k = 0;
        hold_r = 2'b11;
        while (!timeout_err && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 100) hold_r = {ch0_ready, ch1_ready};
        end
        chk("t4_delay", k, 261);
        chk("t4_hold_ready", hold_r, 2'b01);
        chk("t4_released", {busy, ch0_ready, ch1_ready}, 3'b011);
        @(negedge clk);
        chk("t4_pulse_width", timeout_err, 0);
        send(0, 8'h77, 0, 1);
        wait_idle("t4_idle");
        chk("t4_ch0_granted", {log_own[nl-1], log_data[nl-1]}, {1'b0, 8'h77});

        // 5: driver never drops ready
        stuck = 1;
        base = nl;
        send(0, 8'h99, 1, 1);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        chk("t5_exit", k, 17);
        chk("t5_count", nl - base, 1);
        chk("t5_byte", {log_data[base], log_dc[base]}, {8'h99, 1'b1});
        stuck = 0;

        // 6: reset asserted during WAIT_BUSY
        base = nl;
        send(0, 8'h42, 1, 0);
        @(negedge clk);
        chk("t6_in_wait", {busy, spi_ready}, 2'b10);
        #2 resetn = 0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_outs", {spi_transmitt, spi_data, oled_dc, spi_cs_release, owner, timeout_err}, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        chk("t6_ready", ch0_ready, 1);
        send(0, 8'hC0, 0, 1);
        chk("t6_latency", lat, 1);
        wait_idle("t6_idle");
        chk("t6_count", nl - base, 2);
        chk("t6_byte", {log_data[nl-1], log_rel[nl-1]}, {8'hC0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
